// File: rtl/sram_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// sram_ctrl_pkg
//
// Shared definitions for the MEM-stage SRAM controller: the access FSM state
// encoding, the SRAM and CPU bus widths, and small helpers that keep the address
// mapping and state classification in one place.
// -----------------------------------------------------------------------------
package sram_ctrl_pkg;

    // External asynchronous SRAM: 256K x 16.
    localparam int SRAM_AW = 18;
    localparam int SRAM_DW = 16;

    // CPU-side request bus.
    localparam int CPU_AW = 32;
    localparam int CPU_DW = 32;

    // One CPU word is two SRAM half-words, so the word index is one bit
    // narrower than the SRAM address.
    localparam int WORD_IW = SRAM_AW - 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_LO = 3'd1,
        RD_HI = 3'd2,
        WR_LO = 3'd3,
        WR_HI = 3'd4,
        DONE  = 3'd5
    } state_e;

    // True for the four states that hold the SRAM bus for a timed phase.
    function automatic logic is_phase_state(input state_e s);
        return (s == RD_LO) || (s == RD_HI) || (s == WR_LO) || (s == WR_HI);
    endfunction

    // CPU byte address -> SRAM word index. Addresses below the base wrap
    // around; only the low WORD_IW bits of the word offset are kept.
    function automatic logic [WORD_IW-1:0] word_index(
        input logic [CPU_AW-1:0] addr,
        input logic [CPU_AW-1:0] base
    );
        return WORD_IW'((addr - base) >> 2);
    endfunction

endpackage : sram_ctrl_pkg

// File: rtl/sram_controller_if.sv
// -----------------------------------------------------------------------------
// sram_controller_if
//
// MEM-stage request bus between the pipeline (master) and the SRAM
// controller (slave).
//   rd_en    master->slave  load request
//   wr_en    master->slave  store request
//   addr     master->slave  word-aligned CPU byte address
//   wr_data  master->slave  store data
//   rd_data  slave->master  load data, valid while ready is high after a read
//   ready    slave->master  low while a request is in flight (freeze = ~ready)
// -----------------------------------------------------------------------------
interface sram_controller_if;

    logic                              rd_en;
    logic                              wr_en;
    logic [sram_ctrl_pkg::CPU_AW-1:0]  addr;
    logic [sram_ctrl_pkg::CPU_DW-1:0]  wr_data;
    logic [sram_ctrl_pkg::CPU_DW-1:0]  rd_data;
    logic                              ready;

    modport master (
        output rd_en,
        output wr_en,
        output addr,
        output wr_data,
        input  rd_data,
        input  ready
    );

    modport slave (
        input  rd_en,
        input  wr_en,
        input  addr,
        input  wr_data,
        output rd_data,
        output ready
    );

endinterface : sram_controller_if

// File: rtl/sram_controller.sv
// -----------------------------------------------------------------------------
// sram_controller
//
// Serves 32-bit MEM-stage loads and stores from a 16-bit asynchronous SRAM as
// two half-word accesses (low half first). Each half-word phase holds the SRAM
// bus for PHASE_CYCLES cycles; ready is dropped for the whole access so the
// pipeline freezes, then pulses high for one DONE cycle.
//
// Parameters
//   BASE_ADDR     CPU byte address mapped to SRAM word 0
//   PHASE_CYCLES  cycles per half-word phase (>= 1)
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   bus          request bus (slave side): rd_en, wr_en, addr, wr_data,
//                rd_data, ready
//   sram_addr    SRAM half-word address
//   sram_dq_out  write data to the DQ pad
//   sram_dq_in   read data from the DQ pad
//   sram_dq_oe   pad output enable, 1 = controller drives DQ
//   sram_we_n    SRAM write strobe, active-low
// -----------------------------------------------------------------------------
module sram_controller
    import sram_ctrl_pkg::*;
#(
    parameter logic [CPU_AW-1:0] BASE_ADDR    = 32'd1024,
    parameter int unsigned       PHASE_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst,
    sram_controller_if.slave    bus,
    output logic [SRAM_AW-1:0]  sram_addr,
    output logic [SRAM_DW-1:0]  sram_dq_out,
    input  logic [SRAM_DW-1:0]  sram_dq_in,
    output logic                sram_dq_oe,
    output logic                sram_we_n
);

    // Phase counter wide enough to hold PHASE_CYCLES-1 (one bit minimum).
    localparam int              PW         = $clog2(PHASE_CYCLES) + 1;
    localparam logic [PW-1:0]   PHASE_LAST = PW'(PHASE_CYCLES - 1);

    state_e                 state_q, state_d;
    logic [PW-1:0]          phase_q, phase_d;
    logic [CPU_DW-1:0]      rd_data_q, rd_data_d;

    logic                   phase_done;
    logic [WORD_IW-1:0]     word_idx;

    // Last cycle of the current half-word phase. Only meaningful in the
    // four timed states; elsewhere the counter sits at zero.
    assign phase_done = (phase_q == PHASE_LAST);

    // The request inputs are frozen by the pipeline while ready is low, so
    // the address is decoded live rather than latched at request time.
    assign word_idx = word_index(bus.addr, BASE_ADDR);

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: state flops are written with non-blocking assignments only, so
    // every flop samples the pre-edge value of every other flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            phase_q   <= '0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            rd_data_q <= rd_data_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every signal assigned in a combinational block gets a default on
    // the first line, so no path through the case can infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                // A simultaneous read and write is served as a read only.
                if (bus.rd_en) begin
                    state_d = RD_LO;
                end else if (bus.wr_en) begin
                    state_d = WR_LO;
                end
            end
            RD_LO: if (phase_done) state_d = RD_HI;
            RD_HI: if (phase_done) state_d = DONE;
            WR_LO: if (phase_done) state_d = WR_HI;
            WR_HI: if (phase_done) state_d = DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Phase counter: counts cycles within a timed state and is cleared on
    // every state change, so each phase starts from zero.
    always_comb begin
        phase_d = '0;
        if (is_phase_state(state_q) && (state_d == state_q)) begin
            phase_d = phase_q + PW'(1);
        end
    end

    // Read capture: each half is sampled on the last cycle of its phase, when
    // the asynchronous SRAM has had the longest time to settle.
    always_comb begin
        rd_data_d = rd_data_q;
        if (phase_done) begin
            case (state_q)
                RD_LO:   rd_data_d[15:0]  = sram_dq_in;
                RD_HI:   rd_data_d[31:16] = sram_dq_in;
                default: rd_data_d        = rd_data_q;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Output decode (Moore on state, except ready in IDLE)
    // -------------------------------------------------------------------------
    always_comb begin
        sram_addr   = '0;
        sram_dq_out = '0;
        sram_dq_oe  = 1'b0;
        sram_we_n   = 1'b1;
        bus.ready   = 1'b0;
        case (state_q)
            IDLE: begin
                // Combinational so a new request freezes the pipeline in the
                // same cycle it is presented.
                bus.ready = ~(bus.rd_en | bus.wr_en);
            end
            RD_LO: begin
                sram_addr = {word_idx, 1'b0};
            end
            RD_HI: begin
                sram_addr = {word_idx, 1'b1};
            end
            WR_LO: begin
                sram_addr   = {word_idx, 1'b0};
                sram_dq_out = bus.wr_data[15:0];
                sram_dq_oe  = 1'b1;
                sram_we_n   = 1'b0;
            end
            WR_HI: begin
                sram_addr   = {word_idx, 1'b1};
                sram_dq_out = bus.wr_data[31:16];
                sram_dq_oe  = 1'b1;
                sram_we_n   = 1'b0;
            end
            DONE: begin
                bus.ready = 1'b1;
            end
            default: begin
                bus.ready = 1'b0;
            end
        endcase
    end

    assign bus.rd_data = rd_data_q;

endmodule : sram_controller

// File: tb/tb_sram_controller.sv
// -----------------------------------------------------------------------------
// tb_sram_controller
//
// Two controller instances (PHASE_CYCLES = 2 and 1), each with its own
// behavioural SRAM. A select bit routes the shared request stimulus to one
// instance and the other sees an idle bus. Expected load data comes from a
// word-level reference memory per instance; bus timing expectations come from
// the access-timing rules (cycle counts in terms of PHASE_CYCLES).
// -----------------------------------------------------------------------------
module tb_sram_controller;
    import sram_ctrl_pkg::*;

    localparam logic [31:0] BASE = 32'd1024;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Shared stimulus, routed by sel (0 -> dut0, 1 -> dut1).
    logic        sel;
    logic        req_rd, req_wr;
    logic [31:0] req_addr, req_wdata;
    logic        mem_clr;

    sram_controller_if bus0 ();
    sram_controller_if bus1 ();

    assign bus0.rd_en   = req_rd & ~sel;
    assign bus0.wr_en   = req_wr & ~sel;
    assign bus0.addr    = req_addr;
    assign bus0.wr_data = req_wdata;
    assign bus1.rd_en   = req_rd & sel;
    assign bus1.wr_en   = req_wr & sel;
    assign bus1.addr    = req_addr;
    assign bus1.wr_data = req_wdata;

    logic [17:0] sa0, sa1;
    logic [15:0] dqo0, dqo1, dqi0, dqi1;
    logic        oe0, oe1, we_n0, we_n1;

    sram_controller #(.BASE_ADDR(BASE), .PHASE_CYCLES(2)) dut0 (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus0),
        .sram_addr   (sa0),
        .sram_dq_out (dqo0),
        .sram_dq_in  (dqi0),
        .sram_dq_oe  (oe0),
        .sram_we_n   (we_n0)
    );

    sram_controller #(.BASE_ADDR(BASE), .PHASE_CYCLES(1)) dut1 (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus1),
        .sram_addr   (sa1),
        .sram_dq_out (dqo1),
        .sram_dq_in  (dqi1),
        .sram_dq_oe  (oe1),
        .sram_we_n   (we_n1)
    );

    // Behavioural SRAMs: asynchronous read, write while we_n is low. Only the
    // low 10 address bits are decoded; the tests stay within distinct slots.
    logic [15:0] mem0 [1024];
    logic [15:0] mem1 [1024];

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 1024; i++) mem0[i] <= '0;
        end else if (!we_n0) begin
            mem0[sa0[9:0]] <= dqo0;
        end
    end

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 1024; i++) mem1[i] <= '0;
        end else if (!we_n1) begin
            mem1[sa1[9:0]] <= dqo1;
        end
    end

    assign dqi0 = mem0[sa0[9:0]];
    assign dqi1 = mem1[sa1[9:0]];

    // Outputs of the selected instance.
    logic        cur_ready, cur_we_n, cur_oe;
    logic [17:0] cur_addr;
    logic [15:0] cur_dqo;
    logic [31:0] cur_rd;

    always_comb begin
        cur_ready = sel ? bus1.ready   : bus0.ready;
        cur_rd    = sel ? bus1.rd_data : bus0.rd_data;
        cur_we_n  = sel ? we_n1 : we_n0;
        cur_oe    = sel ? oe1   : oe0;
        cur_addr  = sel ? sa1   : sa0;
        cur_dqo   = sel ? dqo1  : dqo0;
    end

    // Word-level reference memories (unwritten words read as zero).
    logic [31:0] ref0 [logic [16:0]];
    logic [31:0] ref1 [logic [16:0]];

    function automatic logic [31:0] ref_get(input logic [16:0] w);
        if (sel) return ref1.exists(w) ? ref1[w] : 32'h0;
        return ref0.exists(w) ? ref0[w] : 32'h0;
    endfunction

    task automatic ref_put(input logic [16:0] w, input logic [31:0] d);
        if (sel) ref1[w] = d;
        else     ref0[w] = d;
    endtask

    function automatic logic [15:0] mem_get(input logic [17:0] sa);
        return sel ? mem1[sa[9:0]] : mem0[sa[9:0]];
    endfunction

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        else             n_pass++;
    endtask

    // One complete access on the selected instance. Cycle 0 is the IDLE cycle
    // in which the request is first presented.
    task automatic do_access(input logic rd, input logic wr, input logic [31:0] a,
                             input logic [31:0] d, input logic [31:0] exp_rd,
                             input string tag);
        int          p, ready_cyc, we_low, bad;
        logic [16:0] w;
        logic        hi, wr_eff;
        logic [15:0] half;
        logic [31:0] got, exp_word;
        p         = sel ? 1 : 2;
        w         = 17'((a - BASE) >> 2);
        wr_eff    = wr & ~rd;
        ready_cyc = -1;
        we_low    = 0;
        bad       = 0;
        got       = '0;
        req_rd = rd; req_wr = wr; req_addr = a; req_wdata = d;
        for (int cyc = 0; cyc < 4 * p + 8; cyc++) begin
            @(negedge clk);
            if (!cur_we_n) we_low++;
            if (cur_ready || cyc == 0) begin
                if (cur_we_n !== 1'b1 || cur_oe !== 1'b0 || cur_addr !== '0 || cur_dqo !== '0) bad++;
            end else begin
                hi   = (cyc > p);
                half = hi ? d[31:16] : d[15:0];
                if (cur_addr !== {w, hi}) bad++;
                if (wr_eff) begin
                    if (cur_we_n !== 1'b0 || cur_oe !== 1'b1 || cur_dqo !== half) bad++;
                end else if (cur_we_n !== 1'b1 || cur_oe !== 1'b0) begin
                    bad++;
                end
            end
            if (cur_ready) begin
                ready_cyc = cyc;
                got       = cur_rd;
                break;
            end
            @(posedge clk); #1;
        end
        check({tag, " ready_cycle"}, ready_cyc, 2 * p + 1);
        check({tag, " we_n_low_cycles"}, we_low, wr_eff ? 2 * p : 0);
        check({tag, " bus_shape_errors"}, bad, 0);
        if (rd) check({tag, " rd_data"}, got, exp_rd);
        if (wr_eff) ref_put(w, d);
        exp_word = ref_get(w);
        check({tag, " sram_lo_half"}, mem_get({w, 1'b0}), {16'h0, exp_word[15:0]});
        check({tag, " sram_hi_half"}, mem_get({w, 1'b1}), {16'h0, exp_word[31:16]});
        // Pipeline advances at the end of the DONE cycle.
        @(posedge clk); #1;
        req_rd = 1'b0; req_wr = 1'b0;
    endtask

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    localparam int NV = 8;
    vec_t vecs [NV];

    initial begin
        vecs[0] = '{1'b0, 1'b1, 32'd1024, 32'hDEAD_BEEF, 32'h0};
        vecs[1] = '{1'b1, 1'b0, 32'd1024, 32'h0,         32'hDEAD_BEEF};
        vecs[2] = '{1'b0, 1'b1, 32'd1028, 32'h1234_5678, 32'h0};
        vecs[3] = '{1'b1, 1'b0, 32'd1028, 32'h0,         32'h1234_5678};
        vecs[4] = '{1'b1, 1'b1, 32'd1024, 32'h0BAD_F00D, 32'hDEAD_BEEF};
        vecs[5] = '{1'b0, 1'b1, 32'd1020, 32'h600D_D00D, 32'h0};
        vecs[6] = '{1'b1, 1'b0, 32'd1020, 32'h0,         32'h600D_D00D};
        vecs[7] = '{1'b1, 1'b0, 32'd1024, 32'h0,         32'hDEAD_BEEF};

        // ---------------- reset ----------------
        sel = 1'b0; req_rd = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0;
        rst = 1'b1; mem_clr = 1'b1;
        repeat (2) @(posedge clk);
        #1 mem_clr = 1'b0;
        @(negedge clk);
        check("reset ready", cur_ready, 1);
        check("reset we_n", cur_we_n, 1);
        check("reset dq_oe", cur_oe, 0);
        check("reset sram_addr", cur_addr, 0);
        check("reset dq_out", cur_dqo, 0);
        check("reset rd_data", cur_rd, 0);
        req_rd = 1'b1;
        #1 check("idle ready with request", cur_ready, 0);
        req_rd = 1'b0;
        @(posedge clk); #1 rst = 1'b0;

        // ---------------- directed table ----------------
        for (int i = 0; i < NV; i++) begin
            do_access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                      vecs[i].exp_rdata, $sformatf("vec%0d", i));
        end

        // ---------------- reset during WR_HI ----------------
        req_wr = 1'b1; req_addr = 32'd1032; req_wdata = 32'h0BAD_CAFE;
        repeat (3) begin @(posedge clk); #1; end
        @(negedge clk);
        check("abort in WR_HI sram_addr", cur_addr, 18'd5);
        check("abort in WR_HI we_n", cur_we_n, 0);
        rst = 1'b1; req_wr = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("after abort we_n", cur_we_n, 1);
        check("after abort rd_data", cur_rd, 0);
        check("after abort sram_addr", cur_addr, 0);
        check("after abort ready", cur_ready, 1);
        @(posedge clk); #1;
        do_access(1'b0, 1'b1, 32'd1032, 32'hCAFE_F00D, 32'h0, "post-abort write");
        do_access(1'b1, 1'b0, 32'd1032, 32'h0, 32'hCAFE_F00D, "post-abort read");

        // ---------------- randomized, PHASE_CYCLES=2 ----------------
        for (int i = 0; i < 40; i++) begin
            int          k;
            logic [31:0] a, d;
            k = $urandom_range(0, 3);
            a = BASE + 32'($urandom_range(0, 15)) * 4;
            d = $urandom;
            do_access(k == 0 || k == 3, k != 0, a, d, ref_get(17'((a - BASE) >> 2)),
                      $sformatf("rand%0d", i));
        end

        // ---------------- PHASE_CYCLES=1 instance ----------------
        sel = 1'b1;
        #1;
        do_access(1'b0, 1'b1, 32'd1024, 32'hA5A5_5A5A, 32'h0, "p1 write");
        do_access(1'b1, 1'b0, 32'd1024, 32'h0, 32'hA5A5_5A5A, "p1 read");
        for (int i = 0; i < 10; i++) begin
            int          k;
            logic [31:0] a, d;
            k = $urandom_range(0, 3);
            a = BASE + 32'($urandom_range(0, 7)) * 4;
            d = $urandom;
            do_access(k == 0 || k == 3, k != 0, a, d, ref_get(17'((a - BASE) >> 2)),
                      $sformatf("p1 rand%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_sram_controller
